sisc_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the SISC datapath (rf, alu, statreg, mux32, mux4). It fetches each instruction over a req/ack instruction-memory handshake, latches it, and walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK, driving every datapath enable and select. It supports conditional branches on the status register, load/store over a data-memory handshake, halt, and a bus-timeout error.

---
 rtl/sisc_seq_ctrl_if.sv | 35 +++
 rtl/sisc_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_sisc_seq_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sisc_seq_ctrl_if.sv
// Instruction/data memory handshakes and datapath control strobes between the
// SISC sequencer (master) and the datapath/memory side (slave).
interface sisc_seq_ctrl_if;
  logic [31:0] ir_in;
  logic        imem_ack;
  logic        dmem_ack;
  logic [3:0]  stat;
  logic        imem_req;
  logic        ir_load;
  logic        pc_write;
  logic        pc_sel;
  logic        rf_we;
  logic        rb_sel;
  logic [1:0]  alu_op;
  logic        stat_en;
  logic        wb_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] ir;
  logic        halted;
  logic        err;
  logic [2:0]  state;

  modport master (
    input  ir_in, imem_ack, dmem_ack, stat,
    output imem_req, ir_load, pc_write, pc_sel, rf_we, rb_sel, alu_op,
           stat_en, wb_sel, dmem_req, dmem_we, ir, halted, err, state
  );

  modport slave (
    output ir_in, imem_ack, dmem_ack, stat,
    input  imem_req, ir_load, pc_write, pc_sel, rf_we, rb_sel, alu_op,
           stat_en, wb_sel, dmem_req, dmem_we, ir, halted, err, state
  );
endinterface

// File: rtl/sisc_seq_ctrl.sv
// Multi-cycle SISC sequencer: 3 (BRA/NOP), 4 (ALU/STR) or 5 (LOD) cycles per instruction with zero-wait acks.
// Stalls in FETCH/MEM while req waits for ack; a wait of TIMEOUT cycles halts with a sticky err.
module sisc_seq_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst_f,
  sisc_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        ir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;

  logic [3:0] opcode, mm;
  logic       is_alu, is_lod, is_str, is_bra, is_hlt, br_taken;
  logic       wait_req, req_ack, timeout_hit;

  assign opcode   = ir_q[31:28];
  assign mm       = ir_q[27:24];
  assign is_alu   = (opcode == 4'h1) || (opcode == 4'h2);
  assign is_lod   = (opcode == 4'h8);
  assign is_str   = (opcode == 4'h9);
  assign is_bra   = (opcode == 4'h4);
  assign is_hlt   = (opcode == 4'hF);
  assign br_taken = (mm == 4'h0) || ((bus.stat & mm) != 4'h0);

  assign wait_req    = (state_q == S_FETCH) || (state_q == S_MEM);
  assign req_ack     = ((state_q == S_FETCH) && bus.imem_ack) ||
                       ((state_q == S_MEM) && bus.dmem_ack);
  // An ack in the final allowed cycle beats the timeout.
  assign timeout_hit = wait_req && !req_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q <= S_RESET;
      ir_q    <= 32'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_FETCH) && bus.imem_ack)
        ir_q <= bus.ir_in;
      if (wait_req && !req_ack)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack)     state_d = S_DECODE;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_DECODE: state_d = is_hlt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_alu)                 state_d = S_WB;
        else if (is_lod || is_str)  state_d = S_MEM;
        else                        state_d = S_FETCH;
      end
      S_MEM: begin
        if (bus.dmem_ack)     state_d = is_lod ? S_WB : S_FETCH;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RESET;
    endcase
  end

  // Everything is forced low while rst_f is high so an abort never leaks a strobe.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.ir_load  = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rb_sel   = 1'b0;
    bus.alu_op   = 2'b00;
    bus.stat_en  = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.halted   = 1'b0;
    bus.err      = 1'b0;
    bus.ir       = 32'd0;
    bus.state    = 3'd0;
    if (!rst_f) begin
      bus.state = state_q;
      bus.ir    = ir_q;
      bus.err   = err_q;
      case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_load  = bus.imem_ack;
        end
        S_EXEC: begin
          if (is_alu) begin
            bus.alu_op  = (opcode == 4'h1) ? 2'b01 : 2'b10;
            bus.stat_en = 1'b1;
          end else if (is_lod || is_str) begin
            bus.alu_op = 2'b11;
          end else begin
            // BRA and NOP-class instructions retire here.
            bus.pc_write = 1'b1;
            bus.pc_sel   = is_bra && br_taken;
          end
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = is_str;
          bus.rb_sel   = is_str;
          bus.pc_write = is_str && bus.dmem_ack;
        end
        S_WB: begin
          bus.rf_we    = 1'b1;
          bus.wb_sel   = is_lod;
          bus.pc_write = 1'b1;
        end
        S_HALT:  bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_seq_ctrl.sv
// Directed-step bench for sisc_seq_ctrl: per-cycle expected control vectors queued and compared mid-cycle.
module tb_sisc_seq_ctrl;

  logic clk = 1'b0;
  logic rst_f;
  always #5 clk = ~clk;

  sisc_seq_ctrl_if bus ();

  sisc_seq_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req, ir_load, pc_write, pc_sel, rf_we, rb_sel;
    logic [1:0] alu_op;
    logic       stat_en, wb_sel, dmem_req, dmem_we, halted, err;
  } obs_t;

  localparam logic [2:0] S_RST = 3'd0, S_FET = 3'd1, S_DEC = 3'd2, S_EXE = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HLT = 3'd6;
  localparam logic [11:0] F_IREQ = 12'h800, F_LD = 12'h400, F_PW = 12'h200, F_PS = 12'h100,
                          F_WE = 12'h080, F_RB = 12'h040, F_SE = 12'h020, F_WS = 12'h010,
                          F_DR = 12'h008, F_DW = 12'h004, F_H = 12'h002, F_ER = 12'h001;

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t exp_q[$];

  function automatic obs_t mk(input logic [2:0] st, input logic [11:0] f, input logic [1:0] op);
    obs_t o;
    o.state    = st;
    o.imem_req = f[11];
    o.ir_load  = f[10];
    o.pc_write = f[9];
    o.pc_sel   = f[8];
    o.rf_we    = f[7];
    o.rb_sel   = f[6];
    o.stat_en  = f[5];
    o.wb_sel   = f[4];
    o.dmem_req = f[3];
    o.dmem_we  = f[2];
    o.halted   = f[1];
    o.err      = f[0];
    o.alu_op   = op;
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.state    = bus.state;
    o.imem_req = bus.imem_req;
    o.ir_load  = bus.ir_load;
    o.pc_write = bus.pc_write;
    o.pc_sel   = bus.pc_sel;
    o.rf_we    = bus.rf_we;
    o.rb_sel   = bus.rb_sel;
    o.alu_op   = bus.alu_op;
    o.stat_en  = bus.stat_en;
    o.wb_sel   = bus.wb_sel;
    o.dmem_req = bus.dmem_req;
    o.dmem_we  = bus.dmem_we;
    o.halted   = bus.halted;
    o.err      = bus.err;
    return o;
  endfunction

  // Inputs for the cycle are already driven; expectation queued, compared at negedge, then advance.
  task automatic step(input string tag, input obs_t e);
    obs_t exp_v;
    obs_t got;
    exp_q.push_back(e);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got   = cur();
    n_checks++;
    assert (got === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_ir(input string tag, input logic [31:0] e);
    n_checks++;
    assert (bus.ir === e) else begin
      n_errors++;
      $error("FAIL %s: observed ir %h expected %h", tag, bus.ir, e);
    end
  endtask

  task automatic do_reset();
    rst_f = 1'b1;
    step("reset_active", mk(S_RST, 12'h000, 2'b00));
    rst_f = 1'b0;
    step("reset_state", mk(S_RST, 12'h000, 2'b00));
  endtask

  task automatic fetch_now(input string tag, input logic [31:0] word);
    bus.ir_in    = word;
    bus.imem_ack = 1'b1;
    step(tag, mk(S_FET, F_IREQ | F_LD, 2'b00));
    bus.imem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_f        = 1'b1;
    bus.ir_in    = 32'd0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.stat     = 4'd0;
    @(posedge clk);
    #1;
    do_reset();
    check_ir("ir_after_reset", 32'd0);

    // ALU reg-reg, ack in first request cycle
    fetch_now("alu_rr_fetch", 32'h1100_0000);
    step("alu_rr_decode", mk(S_DEC, 12'h000, 2'b00));
    check_ir("alu_rr_ir", 32'h1100_0000);
    step("alu_rr_exec", mk(S_EXE, F_SE, 2'b01));
    step("alu_rr_wb", mk(S_WB, F_WE | F_PW, 2'b00));

    // BRA taken / not taken
    bus.stat = 4'b0010;
    fetch_now("bra_t_fetch", 32'h4200_0010);
    step("bra_t_decode", mk(S_DEC, 12'h000, 2'b00));
    step("bra_t_exec", mk(S_EXE, F_PW | F_PS, 2'b00));
    bus.stat = 4'b0001;
    fetch_now("bra_nt_fetch", 32'h4200_0010);
    step("bra_nt_decode", mk(S_DEC, 12'h000, 2'b00));
    step("bra_nt_exec", mk(S_EXE, F_PW, 2'b00));
    bus.stat = 4'b0000;
    fetch_now("bra_uncond_fetch", 32'h4000_0000);
    step("bra_uncond_decode", mk(S_DEC, 12'h000, 2'b00));
    step("bra_uncond_exec", mk(S_EXE, F_PW | F_PS, 2'b00));

    // ALU reg-imm
    fetch_now("alu_ri_fetch", 32'h2000_0001);
    step("alu_ri_decode", mk(S_DEC, 12'h000, 2'b00));
    step("alu_ri_exec", mk(S_EXE, F_SE, 2'b10));
    step("alu_ri_wb", mk(S_WB, F_WE | F_PW, 2'b00));

    // LOD with dmem_ack after 3 wait cycles
    fetch_now("lod_fetch", 32'h8000_0004);
    step("lod_decode", mk(S_DEC, 12'h000, 2'b00));
    step("lod_exec", mk(S_EXE, 12'h000, 2'b11));
    for (int i = 0; i < 3; i++) step("lod_mem_wait", mk(S_MEM, F_DR, 2'b00));
    bus.dmem_ack = 1'b1;
    step("lod_mem_ack", mk(S_MEM, F_DR, 2'b00));
    bus.dmem_ack = 1'b0;
    step("lod_wb", mk(S_WB, F_WE | F_WS | F_PW, 2'b00));

    // STR, zero-wait
    fetch_now("str_fetch", 32'h9000_0004);
    step("str_decode", mk(S_DEC, 12'h000, 2'b00));
    step("str_exec", mk(S_EXE, 12'h000, 2'b11));
    bus.dmem_ack = 1'b1;
    step("str_mem", mk(S_MEM, F_DR | F_DW | F_RB | F_PW, 2'b00));
    bus.dmem_ack = 1'b0;

    // Ack on the 15th wait cycle beats the timeout; NOP then retires
    for (int i = 0; i < 14; i++) step("late_ack_wait", mk(S_FET, F_IREQ, 2'b00));
    fetch_now("late_ack_fetch", 32'h0000_0000);
    step("late_ack_decode", mk(S_DEC, 12'h000, 2'b00));
    step("nop_exec", mk(S_EXE, F_PW, 2'b00));

    // Full timeout: 15 cycles without ack -> HALT with err
    for (int i = 0; i < 15; i++) step("timeout_wait", mk(S_FET, F_IREQ, 2'b00));
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) step("timeout_halt", mk(S_HLT, F_H | F_ER, 2'b00));
    bus.imem_ack = 1'b0;
    do_reset();
    step("post_err_fetch", mk(S_FET, F_IREQ, 2'b00));

    // HLT instruction: held in HALT, no strobes
    fetch_now("hlt_fetch", 32'hF000_0000);
    step("hlt_decode", mk(S_DEC, 12'h000, 2'b00));
    bus.dmem_ack = 1'b1;
    for (int i = 0; i < 20; i++) step("hlt_hold", mk(S_HLT, F_H, 2'b00));
    bus.dmem_ack = 1'b0;
    do_reset();

    // Reset while a data request is pending
    fetch_now("abort_fetch", 32'h8000_0004);
    step("abort_decode", mk(S_DEC, 12'h000, 2'b00));
    step("abort_exec", mk(S_EXE, 12'h000, 2'b11));
    step("abort_mem", mk(S_MEM, F_DR, 2'b00));
    rst_f        = 1'b1;
    bus.dmem_ack = 1'b1;
    step("abort_reset_cycle", mk(S_RST, 12'h000, 2'b00));
    rst_f        = 1'b0;
    bus.dmem_ack = 1'b0;
    step("abort_reset_state", mk(S_RST, 12'h000, 2'b00));
    check_ir("abort_ir_cleared", 32'd0);
    step("abort_refetch", mk(S_FET, F_IREQ, 2'b00));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
